stereo_interleave: RTL and testbench
====================================

Name: stereo_interleave

Overview:
- Merges separate left and right audio sample FIFOs into a single interleaved output FIFO stream: L0, R0, L1, R1, ...
- Inverse of the channel splitter that fans one stream out to left/right FIFOs.
- Sits at the audio back end of the FM demod chain, feeding the single-stream output FIFO or host readback.
- Pops left and right in lockstep so channel alignment can never slip.

Parameters:
DATA_WIDTH, 32, width of each sample word on all data ports
COUNT_WIDTH, 16, width of the interleaved-pair counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_left_dout  input  DATA_WIDTH  head word of left FIFO (first-word-fall-through, valid while !in_left_empty)
in_left_empty  input  1  left FIFO empty
in_left_rd_en  output  1  pop left FIFO this cycle
in_right_dout  input  DATA_WIDTH  head word of right FIFO (FWFT)
in_right_empty  input  1  right FIFO empty
in_right_rd_en  output  1  pop right FIFO this cycle
out_din  output  DATA_WIDTH  word written to output FIFO
out_full  input  1  output FIFO full
out_wr_en  output  1  write strobe to output FIFO
pair_count  output  COUNT_WIDTH  number of complete L/R pairs written, registered

Behaviour:
- Interface fixed: single clock `clock`; `reset` is asynchronous, active-high.
- Registers: state, left_q, right_q, pair_count.
  - On reset: state=S_READ; left_q, right_q, pair_count = 0.
- Outputs are combinational from state/inputs. Default value of all outputs is 0, including throughout reset.
- FIFO semantics: FWFT. A pop asserts rd_en in the same cycle as the data is sampled from dout.
- States:
  - S_READ:
    - if !in_left_empty && !in_right_empty: assert both rd_en, latch left_q<=in_left_dout and right_q<=in_right_dout, go to S_WR_L.
    - otherwise hold; no rd_en.
  - S_WR_L:
    - if !out_full: out_din=left_q, out_wr_en=1, go to S_WR_R.
    - otherwise hold with wr_en=0.
  - S_WR_R:
    - if !out_full: out_din=right_q, out_wr_en=1, pair_count<=pair_count+1.
      - if both inputs are also non-empty in the same cycle: pop both, latch the new pair, go to S_WR_L.
      - otherwise go to S_READ.
    - otherwise hold; no pop.
  - Any illegal state encoding: go to S_READ, no strobes asserted.
- Lockstep rule:
  - in_left_rd_en == in_right_rd_en in every cycle.
  - Never pop one channel alone. One FIFO empty blocks both.
- Throughput:
  - Steady state: 1 output word per cycle (2 cycles per pair) with the back-to-back pop in S_WR_R.
  - Latency: first left word appears on out_din 1 cycle after the pop.
- Data is passed bit-exact, with no arithmetic on samples.
- pair_count wraps modulo 2^COUNT_WIDTH (0xFFFF+1 -> 0).
- out_full asserted mid-pair:
  - the pending word is held in its register and retried.
  - left_q/right_q are never overwritten until right_q has been written.
- Reset mid-pair: the latched pair is discarded, with no further writes. Pops already issued are not replayed.

Decomposition:
- Shared package audio_pkg: state enum stereo_il_state_t {S_READ, S_WR_L, S_WR_R}, 2-bit.
- Default DATA_WIDTH constant is shared with the splitter.
- No sub-module; single FSM plus datapath registers.

Test Plan:
- Basic pair: left FIFO {0x11}, right {0x22}, out never full -> out writes 0x11 then 0x22 on consecutive cycles; pair_count=1; each rd_en pulses exactly once, simultaneously.
- Streaming: left {1,2,3,4}, right {0xA,0xB,0xC,0xD} preloaded -> out sequence 1,A,2,B,3,C,4,D with out_wr_en high 8 consecutive cycles; pair_count=4.
- Channel imbalance: left {5,6}, right {7}, right's second word arrives 10 cycles later -> out 5,7, then stall with no rd_en for 10 cycles, then 6,8. rd_en is never asserted on one channel alone.
- Backpressure: out_full asserted for 5 cycles while in S_WR_R with right_q=0x22 -> out_wr_en=0 and no pops during the stall; 0x22 is written on the cycle full deasserts; no word is lost or duplicated.
- Counter wrap: COUNT_WIDTH=4, stream 17 pairs -> pair_count reads 15 after pair 15, 0 after pair 16, 1 after pair 17.
- Reset mid-operation: assert reset in S_WR_L with left_q=0x33 -> all outputs 0 immediately; after release, state is S_READ, pair_count=0, and 0x33 is never written.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio back-end blocks (splitter / interleaver).
package audio_pkg;

  // Sample word width shared by the channel splitter and the interleaver.
  localparam int AUDIO_DATA_WIDTH = 32;

  // Interleaver FSM states.
  typedef enum logic [1:0] {
    S_READ = 2'd0,
    S_WR_L = 2'd1,
    S_WR_R = 2'd2
  } stereo_il_state_t;

endpackage

// File: rtl/stereo_interleave.sv
// Merges left/right FWFT FIFOs into one interleaved stream L0,R0,L1,R1,...
// Both channels are always popped together so alignment cannot slip.
//
// state  | meaning
// S_READ | waiting for both input FIFOs to hold a word; pops both when ready
// S_WR_L | writing the latched left sample (held while out_full)
// S_WR_R | writing the latched right sample; may pop the next pair back-to-back
module stereo_interleave
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_left_dout,
  input  logic                   in_left_empty,
  output logic                   in_left_rd_en,
  input  logic [DATA_WIDTH-1:0]  in_right_dout,
  input  logic                   in_right_empty,
  output logic                   in_right_rd_en,
  output logic [DATA_WIDTH-1:0]  out_din,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [COUNT_WIDTH-1:0] pair_count
);

  stereo_il_state_t       state_q, state_d;
  logic [DATA_WIDTH-1:0]  left_q, right_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                  pop;
  logic                  load;
  logic                  count_inc;
  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  both_avail;

  assign both_avail = !in_left_empty && !in_right_empty;

  // Next-state and strobe decode; a single pop signal drives both channels.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    count_inc = 1'b0;
    wr        = 1'b0;
    din       = '0;
    case (state_q)
      S_READ: begin
        if (both_avail) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = S_WR_L;
        end
      end
      S_WR_L: begin
        if (!out_full) begin
          wr      = 1'b1;
          din     = left_q;
          state_d = S_WR_R;
        end
      end
      S_WR_R: begin
        if (!out_full) begin
          wr        = 1'b1;
          din       = right_q;
          count_inc = 1'b1;
          if (both_avail) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = S_WR_L;
          end else begin
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_READ;
      end
    endcase
  end

  // Strobes are forced low while reset is held so nothing is popped or written.
  always_comb begin
    in_left_rd_en  = pop && !reset;
    in_right_rd_en = pop && !reset;
    out_wr_en      = wr && !reset;
    out_din        = reset ? '0 : din;
  end

  assign pair_count = count_q;

  // State, sample latches and pair counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      left_q  <= '0;
      right_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        left_q  <= in_left_dout;
        right_q <= in_right_dout;
      end
      if (count_inc) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stereo_interleave.sv
// Scoreboard bench for stereo_interleave: stimulus pushes expected output
// words, a negedge monitor pops and compares every DUT write.
module tb_stereo_interleave;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_left_dout, in_right_dout, out_din;
  logic          in_left_empty, in_right_empty;
  logic          in_left_rd_en, in_right_rd_en;
  logic          out_full, out_wr_en;
  logic [CW-1:0] pair_count;

  stereo_interleave #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_left_dout   (in_left_dout),
    .in_left_empty  (in_left_empty),
    .in_left_rd_en  (in_left_rd_en),
    .in_right_dout  (in_right_dout),
    .in_right_empty (in_right_empty),
    .in_right_rd_en (in_right_rd_en),
    .out_din        (out_din),
    .out_full       (out_full),
    .out_wr_en      (out_wr_en),
    .pair_count     (pair_count)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int pops = 0;
  int wr_cnt = 0;
  int cur_run = 0;
  int max_run = 0;
  int first_pop = -1;
  int first_wr = -1;
  bit pop_flag = 1'b0;

  // Monitor: lockstep check, scoreboard compare, pop/write bookkeeping.
  always @(negedge clock) begin
    cycle++;
    pop_flag = 1'b0;
    if (!reset) begin
      checks++;
      if (in_left_rd_en != in_right_rd_en)
        $display("FAIL lockstep cycle %0d: left_rd_en=%0b right_rd_en=%0b required equal",
                 cycle, in_left_rd_en, in_right_rd_en);
      else passes++;
      if (in_left_rd_en && in_right_rd_en) begin
        pop_flag = 1'b1;
        pops++;
        if (first_pop < 0) first_pop = cycle;
      end
      if (out_wr_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cycle;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        checks++;
        if (out_full)
          $display("FAIL write_while_full cycle %0d: out_wr_en=1 required 0", cycle);
        else if (exp_q.size() == 0)
          $display("FAIL unexpected_write cycle %0d: got %h required no write", cycle, out_din);
        else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (out_din !== e)
            $display("FAIL out_data cycle %0d: got %h required %h", cycle, out_din, e);
          else passes++;
        end
      end else begin
        cur_run = 0;
      end
    end
  end

  task automatic refresh();
    in_left_empty  = (lq.size() == 0);
    in_right_empty = (rq.size() == 0);
    in_left_dout   = (lq.size() != 0) ? lq[0] : '0;
    in_right_dout  = (rq.size() != 0) ? rq[0] : '0;
  endtask

  // One clock: apply the pops the DUT issued on the edge, then re-present FIFO heads.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pop_flag) begin
      if (lq.size() != 0) void'(lq.pop_front());
      if (rq.size() != 0) void'(rq.pop_front());
    end
    refresh();
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h required %h", name, act, req);
    else passes++;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lq.push_back(l);
    rq.push_back(r);
    exp_q.push_back(l);
    exp_q.push_back(r);
    refresh();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_timeout: %0d words pending required 0", name, exp_q.size());
    else passes++;
    tick();
  endtask

  task automatic clear_stats();
    pops = 0;
    max_run = 0;
    first_pop = -1;
    first_wr = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0, n;
    reset = 1'b1;
    out_full = 1'b0;
    refresh();
    repeat (3) tick();
    chk("reset_pair_count", DW'(pair_count), 0);
    chk("reset_wr_en", DW'(out_wr_en), 0);
    reset = 1'b0;
    tick();

    // Basic pair
    clear_stats();
    push_pair(32'h11, 32'h22);
    drain("basic");
    chk("basic_pair_count", DW'(pair_count), 1);
    chk("basic_pops", DW'(pops), 1);
    chk("basic_latency", DW'(first_wr - first_pop), 1);
    chk("basic_run", DW'(max_run), 2);

    // Streaming
    clear_stats();
    lq = '{32'h1, 32'h2, 32'h3, 32'h4};
    rq = '{32'hA, 32'hB, 32'hC, 32'hD};
    exp_q = '{32'h1, 32'hA, 32'h2, 32'hB, 32'h3, 32'hC, 32'h4, 32'hD};
    refresh();
    drain("stream");
    chk("stream_run", DW'(max_run), 8);
    chk("stream_pops", DW'(pops), 4);
    chk("stream_pair_count", DW'(pair_count), 5);

    // Channel imbalance
    clear_stats();
    lq = '{32'h5, 32'h6};
    rq = '{32'h7};
    exp_q = '{32'h5, 32'h7, 32'h6, 32'h8};
    refresh();
    repeat (10) tick();
    chk("imbal_gap_pops", DW'(pops), 1);
    chk("imbal_gap_pending", DW'(exp_q.size()), 2);
    rq.push_back(32'h8);
    refresh();
    drain("imbal");
    chk("imbal_pops", DW'(pops), 2);
    chk("imbal_pair_count", DW'(pair_count), 7);

    // Backpressure while in S_WR_R
    clear_stats();
    w0 = wr_cnt;
    push_pair(32'h21, 32'h22);
    n = 0;
    while (wr_cnt == w0 && n < 50) begin
      tick();
      n++;
    end
    out_full = 1'b1;
    push_pair(32'h23, 32'h24);
    p0 = pops;
    repeat (5) tick();
    chk("bp_stall_pops", DW'(pops - p0), 0);
    chk("bp_stall_writes", DW'(wr_cnt - w0), 1);
    out_full = 1'b0;
    drain("bp");
    chk("bp_pops", DW'(pops), 2);
    chk("bp_pair_count", DW'(pair_count), 9);

    // Counter wrap with a 4-bit counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 17; i++) begin
      push_pair(DW'(i), DW'(32'h100 + i));
      drain("wrap");
      chk($sformatf("wrap_count_%0d", i), DW'(pair_count), DW'(i % 16));
    end

    // Reset mid-pair in S_WR_L
    clear_stats();
    out_full = 1'b1;
    lq.push_back(32'h33);
    rq.push_back(32'h34);
    refresh();
    n = 0;
    while (pops == 0 && n < 50) begin
      tick();
      n++;
    end
    lq.push_back(32'h55);
    rq.push_back(32'h56);
    refresh();
    repeat (2) tick();
    out_full = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wr_en", DW'(out_wr_en), 0);
    chk("rst_rd_en", DW'({in_left_rd_en, in_right_rd_en}), 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_pair_count", DW'(pair_count), 0);
    repeat (2) tick();
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h56);
    reset = 1'b0;
    #1;
    chk("rst_release_rd_en", DW'(in_left_rd_en), 1);
    drain("rst");
    chk("rst_pair_count_after", DW'(pair_count), 1);
    chk("final_pending", DW'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
